jpeg_restart_ctrl: RTL and testbench

- Sequences restart-interval (DRI) handling around the MCU processor.
- Counts completed blocks and MCUs, and stalls the MCU processor at each interval boundary.
- Commands the bit buffer to byte-align, then verifies and consumes the RSTn marker, resynchronising past garbage bytes if needed.
- Pulses a DC-predictor reset before decode resumes. Sits between jpeg_mcu_proc, jpeg_mcu_id and the bit buffer.

---
 rtl/jpeg_pkg.sv | 15 +
 rtl/jpeg_rst_marker_match.sv | 14 +
 rtl/jpeg_restart_ctrl.sv | 159 +++++++++++++++
 tb/tb_jpeg_restart_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared JPEG mode constants, RST marker constants, restart FSM states
package jpeg_pkg;
   localparam logic [1:0] JPEG_MONOCHROME  = 2'd0;
   localparam logic [1:0] JPEG_YCBCR_444   = 2'd1;
   localparam logic [1:0] JPEG_YCBCR_420   = 2'd2;
   localparam logic [1:0] JPEG_UNSUPPORTED = 2'd3;
   localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
   localparam logic [4:0] JPEG_RST_BASE      = 5'b11010;
   typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_ALIGN, ST_MATCH, ST_DCRST} rst_state_t;
   // Unsupported modes fall back to one block per MCU
   function automatic logic [2:0] blocks_per_mcu(input logic [1:0] mode);
      return (mode == JPEG_MONOCHROME || mode == JPEG_UNSUPPORTED) ? 3'd1 :
             (mode == JPEG_YCBCR_444) ? 3'd3 : 3'd6;
   endfunction
endpackage

// File: rtl/jpeg_rst_marker_match.sv
// jpeg_rst_marker_match: classifies a 16-bit stream head as the expected RSTn, another RSTn, or neither
module jpeg_rst_marker_match
   import jpeg_pkg::*;
(
   input  logic [15:0] i_head,
   input  logic [2:0]  i_exp_n,
   output logic        o_match,
   output logic        o_any_rst,
   output logic [2:0]  o_found_n
);
   assign o_any_rst = (i_head[15:8] == JPEG_MARKER_PREFIX) && (i_head[7:3] == JPEG_RST_BASE);
   assign o_found_n = i_head[2:0];
   assign o_match   = o_any_rst && (i_head[2:0] == i_exp_n);
endmodule

// File: rtl/jpeg_restart_ctrl.sv
// jpeg_restart_ctrl: restart-interval sequencer (hold, align, RSTn consume, DC reset); JPEG_RST_STATS_EN adds counters
module jpeg_restart_ctrl
   import jpeg_pkg::*;
#(
   parameter int MAX_SEARCH = 64,
   parameter int CNT_W      = 16
)
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             img_start_i,
   input  logic [1:0]       img_mode_i,
   input  logic             dri_valid_i,
   input  logic [15:0]      dri_value_i,
   input  logic             blk_done_i,
   input  logic             last_mcu_i,
   output logic             hold_o,
   output logic             align_req_o,
   input  logic             align_ack_i,
   input  logic             inport_valid_i,
   input  logic [31:0]      inport_data_i,
   output logic [5:0]       inport_pop_o,
   output logic             dc_reset_o,
   output logic [2:0]       exp_rst_o,
   output logic [CNT_W-1:0] mcu_count_o,
   output logic             rst_err_o
`ifdef JPEG_RST_STATS_EN
   ,
   output logic [15:0]      stat_restarts_o,
   output logic [15:0]      stat_skipped_o
`endif
);
   localparam int SW = $clog2(MAX_SEARCH + 1);

   rst_state_t       r_state;
   logic [2:0]       r_blk_cnt;
   logic [2:0]       r_exp;
   logic [CNT_W-1:0] r_mcu_cnt;
   logic [SW-1:0]    r_search;
   logic             r_hold;
   logic             r_align;
   logic             r_dc;
   logic             r_err;
   logic [2:0]       w_bpm;
   logic             w_mcu_done;
   logic             w_boundary;
   logic             w_match;
   logic             w_any;
   logic [2:0]       w_found;
   logic             w_timeout;
   logic             w_pop8;
   logic             w_pop16;
   logic             w_unused;

   assign w_unused = ^inport_data_i[15:0];

   jpeg_rst_marker_match u_match (
      .i_head    (inport_data_i[31:16]),
      .i_exp_n   (r_exp),
      .o_match   (w_match),
      .o_any_rst (w_any),
      .o_found_n (w_found)
   );

   assign w_bpm      = blocks_per_mcu(img_mode_i);
   assign w_mcu_done = (r_state == ST_RUN) && blk_done_i && (r_blk_cnt >= w_bpm - 3'd1);
   assign w_boundary = dri_valid_i && (dri_value_i != 16'd0) && !last_mcu_i &&
                       ((r_mcu_cnt + 1'b1) == CNT_W'(dri_value_i));
   assign w_timeout  = (r_state == ST_MATCH) && (r_search == SW'(MAX_SEARCH));
   assign w_pop16    = (r_state == ST_MATCH) && !w_timeout && inport_valid_i && w_any;
   assign w_pop8     = (r_state == ST_MATCH) && !w_timeout && inport_valid_i && !w_any;

   // Pop is combinational so it acts on the same head that was classified
   assign inport_pop_o = w_pop16 ? 6'd16 : w_pop8 ? 6'd8 : 6'd0;
   assign hold_o       = r_hold;
   assign align_req_o  = r_align;
   assign dc_reset_o   = r_dc;
   assign exp_rst_o    = r_exp;
   assign mcu_count_o  = r_mcu_cnt;
   assign rst_err_o    = r_err;

   // Restart FSM with block/MCU counters and registered control outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || img_start_i) begin
         r_state   <= ST_IDLE;
         r_blk_cnt <= '0;
         r_exp     <= '0;
         r_mcu_cnt <= '0;
         r_search  <= '0;
         r_hold    <= 1'b0;
         r_align   <= 1'b0;
         r_dc      <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_dc <= 1'b0;
         if (r_state == ST_RUN && blk_done_i)
            r_blk_cnt <= w_mcu_done ? 3'd0 : r_blk_cnt + 3'd1;
         case (r_state)
            ST_IDLE: r_state <= ST_RUN;
            ST_RUN: begin
               if (w_mcu_done && w_boundary) begin
                  r_mcu_cnt <= '0;
                  r_hold    <= 1'b1;
                  r_align   <= 1'b1;
                  r_state   <= ST_ALIGN;
               end else if (w_mcu_done) begin
                  r_mcu_cnt <= last_mcu_i ? '0 : r_mcu_cnt + 1'b1;
               end
            end
            ST_ALIGN: begin
               if (align_ack_i) begin
                  r_align <= 1'b0;
                  r_state <= ST_MATCH;
               end
            end
            ST_MATCH: begin
               if (w_timeout || w_pop16) begin
                  r_dc    <= 1'b1;
                  r_state <= ST_DCRST;
               end
               if (w_timeout || (w_pop16 && !w_match))
                  r_err <= 1'b1;
               if (w_pop16 && !w_match)
                  r_exp <= w_found;
               if (w_pop8)
                  r_search <= r_search + 1'b1;
            end
            ST_DCRST: begin
               r_exp    <= r_exp + 3'd1;
               r_search <= '0;
               r_hold   <= 1'b0;
               r_state  <= ST_RUN;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef JPEG_RST_STATS_EN
   logic [15:0] r_stat_rst;
   logic [15:0] r_stat_skip;

   assign stat_restarts_o = r_stat_rst;
   assign stat_skipped_o  = r_stat_skip;

   // Saturating counts of completed restarts and bytes skipped while hunting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || img_start_i) begin
         r_stat_rst  <= '0;
         r_stat_skip <= '0;
      end else begin
         if (r_state == ST_DCRST && r_stat_rst != 16'hFFFF)
            r_stat_rst <= r_stat_rst + 16'd1;
         if (w_pop8 && r_stat_skip != 16'hFFFF)
            r_stat_skip <= r_stat_skip + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_jpeg_restart_ctrl.sv
// tb_jpeg_restart_ctrl: directed self-checking bench for jpeg_restart_ctrl
module tb_jpeg_restart_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        img_start_i = 1'b0;
   logic [1:0]  img_mode_i = 2'd0;
   logic        dri_valid_i = 1'b0;
   logic [15:0] dri_value_i = 16'd0;
   logic        blk_done_i = 1'b0;
   logic        last_mcu_i = 1'b0;
   logic        hold_o;
   logic        align_req_o;
   logic        align_ack_i = 1'b0;
   logic        inport_valid_i = 1'b0;
   logic [31:0] inport_data_i = 32'd0;
   logic [5:0]  inport_pop_o;
   logic        dc_reset_o;
   logic [2:0]  exp_rst_o;
   logic [15:0] mcu_count_o;
   logic        rst_err_o;
`ifdef JPEG_RST_STATS_EN
   logic [15:0] stat_restarts_o;
   logic [15:0] stat_skipped_o;
`endif
   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   jpeg_restart_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .img_start_i    (img_start_i),
      .img_mode_i     (img_mode_i),
      .dri_valid_i    (dri_valid_i),
      .dri_value_i    (dri_value_i),
      .blk_done_i     (blk_done_i),
      .last_mcu_i     (last_mcu_i),
      .hold_o         (hold_o),
      .align_req_o    (align_req_o),
      .align_ack_i    (align_ack_i),
      .inport_valid_i (inport_valid_i),
      .inport_data_i  (inport_data_i),
      .inport_pop_o   (inport_pop_o),
      .dc_reset_o     (dc_reset_o),
      .exp_rst_o      (exp_rst_o),
      .mcu_count_o    (mcu_count_o),
      .rst_err_o      (rst_err_o)
`ifdef JPEG_RST_STATS_EN
      ,
      .stat_restarts_o(stat_restarts_o),
      .stat_skipped_o (stat_skipped_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic new_image(input logic [1:0] mode, input logic [15:0] dri);
      img_mode_i  = mode;
      dri_valid_i = 1'b1;
      dri_value_i = dri;
      img_start_i = 1'b1;
      tick();
      img_start_i = 1'b0;
      tick();
   endtask

   task automatic blk(input logic last);
      blk_done_i = 1'b1;
      last_mcu_i = last;
      tick();
      blk_done_i = 1'b0;
      last_mcu_i = 1'b0;
   endtask

   // Boundary block, immediate ack, marker RST<n>, then DC reset cycle
   task automatic restart_seq(input logic [2:0] n);
      blk(1'b0);
      align_ack_i = 1'b1;
      tick();
      align_ack_i = 1'b0;
      inport_valid_i = 1'b1;
      inport_data_i = {8'hFF, 5'b11010, n, 16'h1234};
      tick();
      inport_valid_i = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({hold_o, align_req_o, inport_pop_o, dc_reset_o, exp_rst_o, mcu_count_o, rst_err_o} !== 29'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {hold_o, align_req_o, inport_pop_o, dc_reset_o, exp_rst_o, mcu_count_o, rst_err_o});
      end
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_restart_420();
      new_image(2'd2, 16'd2);
      for (int i = 0; i < 6; i++) blk(1'b0);
      checks++;
      if (mcu_count_o !== 16'd1 || hold_o !== 1'b0) begin
         failures++;
         $display("FAIL r420_mcu1 got cnt=%0d hold=%0b exp cnt=1 hold=0", mcu_count_o, hold_o);
      end
      for (int i = 0; i < 6; i++) blk(1'b0);
      checks++;
      if (hold_o !== 1'b1 || align_req_o !== 1'b1 || mcu_count_o !== 16'd0 || inport_pop_o !== 6'd0) begin
         failures++;
         $display("FAIL r420_boundary got hold=%0b req=%0b cnt=%0d pop=%0d exp 1 1 0 0", hold_o, align_req_o, mcu_count_o, inport_pop_o);
      end
      align_ack_i = 1'b1;
      tick();
      align_ack_i = 1'b0;
      inport_valid_i = 1'b1;
      inport_data_i = 32'hFFD0ABCD;
      #1;
      checks++;
      if (align_req_o !== 1'b0 || inport_pop_o !== 6'd16) begin
         failures++;
         $display("FAIL r420_match got req=%0b pop=%0d exp req=0 pop=16", align_req_o, inport_pop_o);
      end
      tick();
      inport_valid_i = 1'b0;
      checks++;
      if (dc_reset_o !== 1'b1 || hold_o !== 1'b1 || inport_pop_o !== 6'd0) begin
         failures++;
         $display("FAIL r420_dcrst got dc=%0b hold=%0b pop=%0d exp 1 1 0", dc_reset_o, hold_o, inport_pop_o);
      end
      tick();
      checks++;
      if (dc_reset_o !== 1'b0 || hold_o !== 1'b0 || exp_rst_o !== 3'd1 || rst_err_o !== 1'b0) begin
         failures++;
         $display("FAIL r420_resume got dc=%0b hold=%0b exp_rst=%0d err=%0b exp 0 0 1 0", dc_reset_o, hold_o, exp_rst_o, rst_err_o);
      end
      for (int i = 0; i < 6; i++) blk(1'b0);
      checks++;
      if (mcu_count_o !== 16'd1) begin
         failures++;
         $display("FAIL r420_mcu3 got=%0d exp=1", mcu_count_o);
      end
      for (int i = 0; i < 6; i++) blk(1'b1);
      checks++;
      if (hold_o !== 1'b0 || align_req_o !== 1'b0 || mcu_count_o !== 16'd0) begin
         failures++;
         $display("FAIL r420_last_mcu got hold=%0b req=%0b cnt=%0d exp 0 0 0", hold_o, align_req_o, mcu_count_o);
      end
   endtask

   task automatic test_wrap_mono();
      int bad = 0;
      new_image(2'd0, 16'd1);
      for (int k = 0; k < 9; k++) begin
         restart_seq(3'(k % 8));
         if (exp_rst_o !== 3'((k + 1) % 8) || hold_o !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL wrap_sequence got %0d bad steps exp 0", bad);
      end
      checks++;
      if (exp_rst_o !== 3'd1 || rst_err_o !== 1'b0) begin
         failures++;
         $display("FAIL wrap_final got exp_rst=%0d err=%0b exp 1 0", exp_rst_o, rst_err_o);
      end
   endtask

   task automatic test_resync();
      new_image(2'd1, 16'd1);
      for (int i = 0; i < 3; i++) blk(1'b0);
      align_ack_i = 1'b1;
      tick();
      align_ack_i = 1'b0;
      inport_valid_i = 1'b1;
      inport_data_i = 32'h00FFFFD0;
      #1;
      checks++;
      if (inport_pop_o !== 6'd8) begin
         failures++;
         $display("FAIL resync_pop1 got=%0d exp=8", inport_pop_o);
      end
      tick();
      inport_data_i = 32'hFFFFD012;
      #1;
      checks++;
      if (inport_pop_o !== 6'd8) begin
         failures++;
         $display("FAIL resync_pop2 got=%0d exp=8", inport_pop_o);
      end
      tick();
      inport_data_i = 32'hFFD01234;
      #1;
      checks++;
      if (inport_pop_o !== 6'd16) begin
         failures++;
         $display("FAIL resync_pop3 got=%0d exp=16", inport_pop_o);
      end
      tick();
      inport_valid_i = 1'b0;
      tick();
      checks++;
      if (exp_rst_o !== 3'd1 || rst_err_o !== 1'b0 || hold_o !== 1'b0) begin
         failures++;
         $display("FAIL resync_done got exp_rst=%0d err=%0b hold=%0b exp 1 0 0", exp_rst_o, rst_err_o, hold_o);
      end
`ifdef JPEG_RST_STATS_EN
      checks++;
      if (stat_skipped_o !== 16'd2 || stat_restarts_o !== 16'd1) begin
         failures++;
         $display("FAIL resync_stats got skip=%0d rst=%0d exp 2 1", stat_skipped_o, stat_restarts_o);
      end
`endif
   endtask

   task automatic test_timeout();
      int n8 = 0;
      int nother = 0;
      bit seen_dc = 0;
      new_image(2'd0, 16'd1);
      blk(1'b0);
      align_ack_i = 1'b1;
      tick();
      align_ack_i = 1'b0;
      inport_valid_i = 1'b1;
      inport_data_i = 32'h12345678;
      for (int i = 0; i < 100 && !seen_dc; i++) begin
         #1;
         if (inport_pop_o == 6'd8) n8++;
         else if (inport_pop_o != 6'd0) nother++;
         tick();
         seen_dc = dc_reset_o;
      end
      inport_valid_i = 1'b0;
      checks++;
      if (!seen_dc || n8 != 64 || nother != 0 || rst_err_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout got dc_seen=%0b pops8=%0d other=%0d err=%0b exp 1 64 0 1", seen_dc, n8, nother, rst_err_o);
      end
      tick();
      checks++;
      if (hold_o !== 1'b0 || exp_rst_o !== 3'd1 || rst_err_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_resume got hold=%0b exp_rst=%0d err=%0b exp 0 1 1", hold_o, exp_rst_o, rst_err_o);
      end
      blk(1'b0);
      checks++;
      if (hold_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_run got hold=%0b exp=1", hold_o);
      end
   endtask

   task automatic test_wrong_marker();
      new_image(2'd0, 16'd1);
      for (int k = 0; k < 3; k++) restart_seq(3'(k));
      blk(1'b0);
      align_ack_i = 1'b1;
      tick();
      align_ack_i = 1'b0;
      inport_valid_i = 1'b1;
      inport_data_i = 32'hFFD50000;
      #1;
      checks++;
      if (exp_rst_o !== 3'd3 || inport_pop_o !== 6'd16) begin
         failures++;
         $display("FAIL wrong_pop got exp_rst=%0d pop=%0d exp 3 16", exp_rst_o, inport_pop_o);
      end
      tick();
      inport_valid_i = 1'b0;
      checks++;
      if (rst_err_o !== 1'b1 || dc_reset_o !== 1'b1) begin
         failures++;
         $display("FAIL wrong_err got err=%0b dc=%0b exp 1 1", rst_err_o, dc_reset_o);
      end
      tick();
      checks++;
      if (exp_rst_o !== 3'd6) begin
         failures++;
         $display("FAIL wrong_exp got=%0d exp=6", exp_rst_o);
      end
   endtask

   task automatic test_abort();
      new_image(2'd0, 16'd1);
      restart_seq(3'd0);
      blk(1'b0);
      align_ack_i = 1'b1;
      tick();
      align_ack_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({hold_o, align_req_o, inport_pop_o, dc_reset_o, exp_rst_o, mcu_count_o, rst_err_o} !== 29'd0) begin
         failures++;
         $display("FAIL abort_rst got=%h exp=0", {hold_o, align_req_o, inport_pop_o, dc_reset_o, exp_rst_o, mcu_count_o, rst_err_o});
      end
      rst_ni = 1'b1;
      tick();
      checks++;
      if (dc_reset_o !== 1'b0 || align_req_o !== 1'b0) begin
         failures++;
         $display("FAIL abort_rst_after got dc=%0b req=%0b exp 0 0", dc_reset_o, align_req_o);
      end
      new_image(2'd0, 16'd1);
      restart_seq(3'd0);
      blk(1'b0);
      checks++;
      if (align_req_o !== 1'b1 || exp_rst_o !== 3'd1) begin
         failures++;
         $display("FAIL abort_align_setup got req=%0b exp_rst=%0d exp 1 1", align_req_o, exp_rst_o);
      end
      img_start_i = 1'b1;
      tick();
      checks++;
      if ({hold_o, align_req_o, inport_pop_o, dc_reset_o, exp_rst_o, mcu_count_o, rst_err_o} !== 29'd0) begin
         failures++;
         $display("FAIL abort_img got=%h exp=0", {hold_o, align_req_o, inport_pop_o, dc_reset_o, exp_rst_o, mcu_count_o, rst_err_o});
      end
      img_start_i = 1'b0;
      tick();
      checks++;
      if (dc_reset_o !== 1'b0 || hold_o !== 1'b0) begin
         failures++;
         $display("FAIL abort_img_after got dc=%0b hold=%0b exp 0 0", dc_reset_o, hold_o);
      end
   endtask

   initial begin
      test_reset();
      test_restart_420();
      test_wrap_mono();
      test_resync();
      test_timeout();
      test_wrong_marker();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
